// File: rtl/stopwatch_uart_pkg.sv
// Shared definitions for the stopwatch UART text path: ASCII codes, FSM
// encoding and message-length helpers.
package stopwatch_uart_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam int MSG_LEN_CRLF = 8;
  localparam int MSG_LEN_LF   = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index of the final byte of a message for the chosen line ending.
  function automatic logic [2:0] msg_last_idx(input bit crlf);
    return crlf ? 3'(MSG_LEN_CRLF - 1) : 3'(MSG_LEN_LF - 1);
  endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD digit to ASCII; non-decimal codes 10-15 render as '?'.
module bcd_to_ascii
  import stopwatch_uart_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_digit <= 4'd9) begin
      o_ascii = ASCII_ZERO + {4'b0000, i_digit};
    end else begin
      o_ascii = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/enhanced_stopwatch_transmit_interface.sv
// Snapshots the stopwatch digits on a report tick and streams "M:SS.T" plus
// EOL into the UART TX FIFO one byte per non-full cycle; extra ticks are dropped.
module enhanced_stopwatch_transmit_interface
  import stopwatch_uart_pkg::*;
#(
  parameter bit P_CRLF = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_tick,
  input  logic [3:0] i_min,
  input  logic [3:0] i_sec_tens,
  input  logic [3:0] i_sec_ones,
  input  logic [3:0] i_tenths,
  input  logic       i_tx_full,
  output logic       o_wr_ascii,
  output logic [7:0] o_ascii,
  output logic       o_busy
);

  localparam logic [2:0] LAST_IDX = msg_last_idx(P_CRLF);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] min_q, min_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] tenths_q, tenths_d;

  logic [3:0] digit_sel;
  logic [7:0] digit_ascii;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      min_q      <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      tenths_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      min_q      <= min_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      tenths_q   <= tenths_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    min_d      = min_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    tenths_d   = tenths_q;
    o_busy     = 1'b0;
    o_wr_ascii = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start_tick) begin
          min_d      = i_min;
          sec_tens_d = i_sec_tens;
          sec_ones_d = i_sec_ones;
          tenths_d   = i_tenths;
          idx_d      = 3'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        o_busy     = 1'b1;
        o_wr_ascii = ~i_tx_full;
        // Start ticks are deliberately not looked at here, even on the final write.
        if (!i_tx_full) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd2:    digit_sel = sec_tens_q;
      3'd3:    digit_sel = sec_ones_q;
      3'd5:    digit_sel = tenths_q;
      default: digit_sel = min_q;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .i_digit (digit_sel),
    .o_ascii (digit_ascii)
  );

  always_comb begin
    case (idx_q)
      3'd1:    o_ascii = ASCII_COLON;
      3'd4:    o_ascii = ASCII_DOT;
      3'd6:    o_ascii = P_CRLF ? ASCII_CR : ASCII_LF;
      3'd7:    o_ascii = ASCII_LF;
      default: o_ascii = digit_ascii;
    endcase
  end

endmodule

// File: doc/enhanced_stopwatch_transmit_interface.md
# enhanced_stopwatch_transmit_interface

Formats the current stopwatch time into an ASCII text line and writes it, one byte per cycle, into the UART transmit FIFO. It is the transmit-side counterpart of the stopwatch command decoder. A one-cycle "report time" tick from the decoder ('R'/'r' command) starts one message. The block snapshots the BCD digits at that moment and streams them out under FIFO back-pressure.

## Interface
- P_CRLF, default 1: 1 ends the line with CR LF (8 bytes); 0 ends it with LF only (7 bytes).

- i_clk, input, 1: system clock.
- i_reset, input, 1: reset, synchronous, active-high.
- i_start_tick, input, 1: one-cycle request to send the current time.
- i_min, input, 4: minutes digit, BCD 0–9.
- i_sec_tens, input, 4: seconds tens digit, BCD 0–5.
- i_sec_ones, input, 4: seconds ones digit, BCD 0–9.
- i_tenths, input, 4: tenths-of-second digit, BCD 0–9.
- i_tx_full, input, 1: UART transmit FIFO full.
- o_wr_ascii, output, 1: FIFO write strobe, one byte per asserted cycle.
- o_ascii, output, 8: byte presented to the FIFO; valid when o_wr_ascii = 1.
- o_busy, output, 1: a message is in progress.

## Operation
- Message format is "M:SS.T", then the EOL. Byte order:
  - i_min
  - 0x3A (':')
  - i_sec_tens
  - i_sec_ones
  - 0x2E ('.')
  - i_tenths
  - 0x0D (CR), only if P_CRLF = 1
  - 0x0A (LF)
- Digit encoding: 0x30 + digit for values 0–9. Any digit value 10–15 is sent as 0x3F ('?').
- State IDLE:
  - o_busy = 0 and o_wr_ascii = 0.
  - On i_start_tick, register all four digits into snapshot registers, clear the byte index to 0, and go to SEND.
- State SEND:
  - o_busy = 1.
  - o_wr_ascii = ~i_tx_full (combinational).
  - o_ascii is selected from the snapshot by the byte index.
  - On each write cycle the index increments.
  - A write at the last index (7 when P_CRLF = 1, 6 when P_CRLF = 0) returns the FSM to IDLE with the index at 0.
- Back-pressure: while i_tx_full = 1, there is no write, the index holds, and o_ascii holds. No byte is dropped or duplicated.
- i_start_tick while in SEND, including the cycle of the final write, is ignored. Requests are not queued.
- Digit inputs may change at any time. Only the snapshot is transmitted.
- Byte index is 3 bits. It never wraps past the last index.

## Timing
- Reset values: state IDLE, index 0, snapshot all 0. Outputs o_wr_ascii = 0, o_busy = 0, o_ascii = 0x30.
- A reset asserted mid-message aborts the message. From the next cycle there are no writes. The remainder of the message is discarded.
- Latency: i_start_tick sampled at edge n → o_busy = 1 and first byte offered in cycle n+1.
- With i_tx_full = 0 throughout, bytes are written in cycles n+1 through n+8 (n+7 when P_CRLF = 0). o_busy = 0 from cycle n+9 (n+8).
- Each stall cycle with i_tx_full = 1 extends the message by exactly one cycle.
- The earliest accepted new start is the first IDLE cycle after the final write.

## Structure
- Shared package stopwatch_uart_pkg holds:
  - ASCII constants: ':', '.', CR, LF, '0', '?'.
  - FSM state encoding: IDLE, SEND.
  - Message length localparams derived from P_CRLF.
- Sub-module bcd_to_ascii: combinational, 4-bit digit in → 8-bit ASCII out, with the '?' rule for values 10–15. The top level instantiates it once, on the index-selected digit.
- The top level holds the FSM, index counter, snapshot registers, and byte mux.

## Test plan
- Reset: assert i_reset for 2 cycles → o_wr_ascii = 0, o_busy = 0, o_ascii = 0x30; no writes for 20 idle cycles.
- Basic message: digits 3,4,5,7 with i_tx_full = 0, one-cycle start → exactly 0x33 0x3A 0x34 0x35 0x2E 0x37 0x0D 0x0A on 8 consecutive cycles starting the cycle after start; o_busy falls after the eighth write.
- Back-pressure: hold i_tx_full = 1 for 4 cycles, starting while the third byte (0x34) is being offered → o_ascii holds 0x34 with o_wr_ascii = 0. The stream then resumes with no skip or duplicate, finishing 4 cycles late.
- Snapshot and ignored start: change the digits to 9,5,9,9 and pulse i_start_tick during the message → the original 3,4,5,7 string is sent, and only 8 bytes are written in total.
- Reset mid-message: assert i_reset after the third write → no further writes. A new start then sends a full 8-byte message from 0x33.
- Bad digit and EOL parameter: i_tenths = 0xC → 0x3F in byte 6. With P_CRLF = 0 → 7 bytes, the last being 0x0A with no 0x0D.
